// File: rtl/lsu_pkg.sv
// Shared types, size encodings and helpers for the load/store bridge.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam int TIMEOUT_CYC_DEF = 255;

   // The reserved size code 2'b11 is handled like a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_H) && off[0]) || (size[1] && (off != 2'b00));
   endfunction

   function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
      if (size[1])
         return 2'b00;
      else if (size == SZ_H)
         return {off[1], 1'b0};
      else
         return off;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated data and
// load right-shift with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        ld_unsigned,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;
   logic        sign;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      shifted = ld_word >> {offset, 3'b000};
      sign    = 1'b0;
      be      = 4'b1111;
      wdata   = st_data;
      ld_data = shifted;
      case (size)
         SZ_B: begin
            be      = 4'b0001 << offset;
            wdata   = {4{st_data[7:0]}};
            sign    = ~ld_unsigned & shifted[7];
            ld_data = {{24{sign}}, shifted[7:0]};
         end
         SZ_H: begin
            be      = 4'b0011 << offset;
            wdata   = {2{st_data[15:0]}};
            sign    = ~ld_unsigned & shifted[15];
            ld_data = {{16{sign}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_bridge.sv
// Core-to-bus load/store bridge with bus timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of aligning them.
module lsu_bridge
   import lsu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wr_dat,
   input  logic [2:0]      funct,
   output logic [XLEN-1:0] rd_dat,
   output logic            rd_valid,
   output logic            stall,
   output logic            fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   lsu_state_t state_q, state_d;

   logic [7:0]      cnt_q;
   logic            is_load_q;
   logic            flt_q;
   logic [1:0]      off_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic [XLEN-1:0] rd_dat_q;
   logic            bus_we_q;
   logic [XLEN-1:0] bus_addr_q;
   logic [3:0]      bus_be_q;
   logic [XLEN-1:0] bus_wdata_q;

   logic            req_any;
   logic            trap;
   logic [1:0]      off_in;
   logic            to_hit;

   logic            start;
   logic            trap_go;
   logic            to_fire;
   logic            ld_cap;
   logic            stall_c;
   logic            bus_req_c;

   logic [1:0]      al_size;
   logic [1:0]      al_off;
   logic            al_uns;
   logic [3:0]      al_be;
   logic [31:0]     al_wdata;
   logic [31:0]     al_ld;

   assign req_any = mem_rd | mem_wr;
   assign to_hit  = (cnt_q == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap   = is_misaligned(funct[1:0], addr[1:0]);
   assign off_in = addr[1:0];
`else
   assign trap   = 1'b0;
   assign off_in = force_align(funct[1:0], addr[1:0]);
`endif

   // In IDLE the lane logic shapes the incoming store; afterwards it
   // extends the returning load word using the captured attributes.
   assign al_size = (state_q == IDLE) ? funct[1:0] : size_q;
   assign al_off  = (state_q == IDLE) ? off_in     : off_q;
   assign al_uns  = (state_q == IDLE) ? funct[2]   : uns_q;

   lsu_align u_align (
      .size        (al_size),
      .offset      (al_off),
      .ld_unsigned (al_uns),
      .st_data     (wr_dat),
      .ld_word     (bus_rdata),
      .be          (al_be),
      .wdata       (al_wdata),
      .ld_data     (al_ld)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      trap_go   = 1'b0;
      to_fire   = 1'b0;
      ld_cap    = 1'b0;
      stall_c   = 1'b0;
      bus_req_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               stall_c = 1'b1;
               if (trap) begin
                  trap_go = 1'b1;
                  state_d = DONE;
               end else begin
                  start   = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            stall_c   = 1'b1;
            bus_req_c = 1'b1;
            if (bus_gnt) begin
               if (!is_load_q) begin
                  state_d = DONE;
               end else if (bus_rvalid) begin
                  ld_cap  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end else if (to_hit) begin
               to_fire = 1'b1;
               state_d = DONE;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (bus_rvalid) begin
               ld_cap  = 1'b1;
               state_d = DONE;
            end else if (to_hit) begin
               to_fire = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Restarts on entry to REQ and on the grant that leads into WAIT.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= 8'd0;
      else if (start || ((state_q == REQ) && bus_gnt))
         cnt_q <= 8'd0;
      else if ((state_q == REQ) || (state_q == WAIT))
         cnt_q <= cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         is_load_q   <= 1'b0;
         flt_q       <= 1'b0;
         off_q       <= 2'b00;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         rd_dat_q    <= '0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= '0;
      end else begin
         if (start) begin
            is_load_q   <= mem_rd;
            flt_q       <= 1'b0;
            off_q       <= off_in;
            size_q      <= funct[1:0];
            uns_q       <= funct[2];
            bus_we_q    <= mem_wr & ~mem_rd;
            bus_addr_q  <= {addr[XLEN-1:2], 2'b00};
            bus_be_q    <= al_be;
            bus_wdata_q <= al_wdata;
         end
         if (trap_go) begin
            is_load_q <= mem_rd;
            flt_q     <= 1'b1;
            rd_dat_q  <= '0;
         end
         if (ld_cap)
            rd_dat_q <= al_ld;
         if (to_fire) begin
            flt_q    <= 1'b1;
            rd_dat_q <= '0;
         end
      end
   end

   // Reset is synchronous, so outputs are masked for the reset cycle itself.
   always_comb begin
      rd_dat    = '0;
      rd_valid  = 1'b0;
      stall     = 1'b0;
      fault     = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_be    = 4'b0000;
      bus_wdata = '0;
      if (!reset) begin
         rd_dat    = rd_dat_q;
         rd_valid  = (state_q == DONE) && is_load_q && !flt_q;
         stall     = stall_c;
         fault     = (state_q == DONE) && flt_q;
         bus_req   = bus_req_c;
         bus_we    = bus_we_q;
         bus_addr  = bus_addr_q;
         bus_be    = bus_be_q;
         bus_wdata = bus_wdata_q;
      end
   end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge: directed cases plus randomized accesses
// against an arithmetic reference model; a second instance checks timeouts.
module tb_lsu_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd, mem_wr;
   logic [31:0] addr, wr_dat;
   logic [2:0]  funct;
   logic [31:0] rd_dat;
   logic        rd_valid, stall, fault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   logic        t_mem_rd;
   logic [31:0] t_addr;
   logic [2:0]  t_funct;
   logic [31:0] t_rd_dat;
   logic        t_rd_valid, t_stall, t_fault;
   logic        t_bus_req, t_bus_we;
   logic [31:0] t_bus_addr;
   logic [3:0]  t_bus_be;
   logic [31:0] t_bus_wdata;
   logic        t_gnt, t_rvalid;
   logic [31:0] t_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_bridge dut (
      .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
      .wr_dat(wr_dat), .funct(funct), .rd_dat(rd_dat), .rd_valid(rd_valid),
      .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   lsu_bridge #(.TIMEOUT_CYC(4)) dut_to (
      .clk(clk), .reset(reset), .mem_rd(t_mem_rd), .mem_wr(1'b0), .addr(t_addr),
      .wr_dat(32'h0), .funct(t_funct), .rd_dat(t_rd_dat), .rd_valid(t_rd_valid),
      .stall(t_stall), .fault(t_fault), .bus_req(t_bus_req), .bus_we(t_bus_we),
      .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
      .bus_gnt(t_gnt), .bus_rvalid(t_rvalid), .bus_rdata(t_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One core access with a bus responder granting after gd REQ cycles and
   // returning data rdl WAIT cycles later (or with the grant when same=1).
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f, input int gd, input int rdl,
                             input logic same, input logic [31:0] rdata);
      int          sz, off, eff, nb, bits, exp_stall;
      logic        trap, is_ld;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_ld;
      logic [63:0] v;
      int          req_cnt, wait_cnt, cyc, n_stall, n_valid, n_fault, n_busreq;
      logic        granted, done, in_req, in_wait;
      logic [31:0] got, rd_at_done, s_addr, s_wdata;
      logic [3:0]  s_be;
      logic        s_we;

      sz    = int'(f[1:0]);
      off   = int'(a % 4);
      is_ld = rd;
      if (sz == 0)      eff = off;
      else if (sz == 1) eff = off - (off % 2);
      else              eff = 0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = ((sz == 1) && (off % 2 == 1)) || ((sz == 2) && (off != 0));
`else
      trap = 1'b0;
`endif
      nb   = 1 << sz;
      e_be = 4'(((1 << nb) - 1) << eff);
      if (sz == 0)      e_wd = (wd & 32'hFF) * 32'h0101_0101;
      else if (sz == 1) e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
      else              e_wd = wd;
      bits = 8 << sz;
      v    = {32'h0, rdata >> (8 * eff)};
      if (bits < 32) begin
         v = v % (64'd1 << bits);
         if (!f[2] && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
      end
      e_ld = v[31:0];
      exp_stall = trap ? 1 : (2 + gd + ((is_ld && !same) ? rdl + 1 : 0));

      mem_rd = rd; mem_wr = wr; addr = a; wr_dat = wd; funct = f; bus_rdata = rdata;
      req_cnt = 0; wait_cnt = 0; cyc = 0; n_stall = 0; n_valid = 0; n_fault = 0;
      n_busreq = 0; granted = 0; done = 0; got = 32'h0; rd_at_done = 32'h0;
      s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0; s_we = 1'b0;
      while (!done && cyc < 300) begin
         bus_gnt = 1'b0; bus_rvalid = 1'b0;
         in_req  = bus_req;
         in_wait = !bus_req && granted && is_ld && !same;
         if (in_req) begin
            if (req_cnt == gd) begin
               bus_gnt = 1'b1;
               bus_rvalid = same;
            end else begin
               bus_rvalid = 1'($urandom_range(0, 1));
            end
         end else if (in_wait && wait_cnt == rdl) begin
            bus_rvalid = 1'b1;
         end
         @(negedge clk);
         if (stall)    n_stall++;
         if (fault)    n_fault++;
         if (rd_valid) begin n_valid++; got = rd_dat; end
         if (bus_req) begin
            if (n_busreq == 0) begin
               s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
            end
            n_busreq++;
         end
         if (!stall) begin done = 1'b1; rd_at_done = rd_dat; end
         @(posedge clk); #1;
         if (in_req) begin
            if (bus_gnt) granted = 1'b1;
            else         req_cnt++;
         end
         if (in_wait) wait_cnt++;
         cyc++;
      end
      mem_rd = 1'b0; mem_wr = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;

      if (!done) check({tag, " completion"}, 32'h0, 32'h1);
      check({tag, " stall cycles"}, n_stall, exp_stall);
      check({tag, " rd_valid pulses"}, n_valid, (is_ld && !trap) ? 1 : 0);
      check({tag, " fault pulses"}, n_fault, trap ? 1 : 0);
      if (trap) begin
         check({tag, " bus_req cycles"}, n_busreq, 0);
         check({tag, " rd_dat"}, rd_at_done, 32'h0);
      end else begin
         check({tag, " bus_req cycles"}, n_busreq, gd + 1);
         check({tag, " bus_addr"}, s_addr, {a[31:2], 2'b00});
         check({tag, " bus_be"}, {28'h0, s_be}, {28'h0, e_be});
         check({tag, " bus_we"}, {31'h0, s_we}, {31'h0, wr & ~rd});
         if (!is_ld) check({tag, " bus_wdata"}, s_wdata, e_wd);
         else        check({tag, " rd_dat"}, got, e_ld);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " stall"}, {31'h0, stall}, 32'h0);
      check({tag, " rd_valid"}, {31'h0, rd_valid}, 32'h0);
      check({tag, " fault"}, {31'h0, fault}, 32'h0);
      check({tag, " bus_req"}, {31'h0, bus_req}, 32'h0);
      check({tag, " rd_dat"}, rd_dat, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rnd;
      int          op, sz;

      reset = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h0; wr_dat = 32'h0;
      funct = 3'b010; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      t_mem_rd = 1'b0; t_addr = 32'h0; t_funct = 3'b010; t_gnt = 1'b0;
      t_rvalid = 1'b0; t_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_be", {28'h0, bus_be}, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      check("reset bus_we", {31'h0, bus_we}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; mem_rd = 1'b0;

      run_access("SB 0x1003", 1'b0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 3'b000, 0, 0, 1'b0, 32'h0);
      run_access("LH 0x2002", 1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b001, 0, 0, 1'b0, 32'h8001_1234);
      run_access("LHU 0x2002", 1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b101, 0, 0, 1'b0, 32'h8001_1234);
      run_access("LW slow bus", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b010, 5, 3, 1'b0, 32'hCAFE_F00D);
      run_access("LW 0x4002", 1'b1, 1'b0, 32'h0000_4002, 32'h0, 3'b010, 0, 0, 1'b0, 32'h1357_9BDF);
      run_access("SH 0x4006", 1'b0, 1'b1, 32'h0000_4006, 32'h1234_BEEF, 3'b001, 1, 0, 1'b0, 32'h0);
      run_access("rd+wr as LB", 1'b1, 1'b1, 32'h0000_5001, 32'hFFFF_FFFF, 3'b000, 0, 1, 1'b0, 32'h0000_F100);
      run_access("LBU gnt+rvalid", 1'b1, 1'b0, 32'h0000_6003, 32'h0, 3'b100, 2, 0, 1'b1, 32'h9A00_0000);

      for (int i = 0; i < 24; i++) begin
         op  = $urandom_range(0, 2);
         sz  = $urandom_range(0, 2);
         rnd = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
         rnd = rnd & ~((32'd1 << sz) - 32'd1);
`endif
         run_access($sformatf("rand%0d", i), op != 1, op != 0, rnd, $urandom,
                    {1'($urandom_range(0, 1)), 2'(sz)}, $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom);
      end

      // Reset while a load sits in WAIT; later bus responses are stray.
      mem_rd = 1'b1; addr = 32'h0000_7000; funct = 3'b010;
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; reset = 1'b1;
      @(negedge clk);
      check_quiet("reset in WAIT");
      @(posedge clk); #1;
      reset = 1'b0; mem_rd = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
      @(negedge clk);
      check_quiet("stray rvalid");
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_gnt = 1'b1;
      @(negedge clk);
      check_quiet("stray gnt");
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      run_access("LW after reset", 1'b1, 1'b0, 32'h0000_7004, 32'h0, 3'b010, 0, 0, 1'b0, 32'h2468_ACE0);

      // Timeout instance: one good load so rd_dat is non-zero first.
      t_mem_rd = 1'b1; t_addr = 32'h0000_3000; t_funct = 3'b010; t_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      t_gnt = 1'b1; t_rvalid = 1'b1;
      @(negedge clk);
      check("to bus_addr", t_bus_addr, 32'h0000_3000);
      check("to bus_be", {28'h0, t_bus_be}, 32'h0000_000F);
      check("to bus_we", {31'h0, t_bus_we}, 32'h0);
      check("to bus_wdata", t_bus_wdata, 32'h0);
      @(posedge clk); #1;
      t_gnt = 1'b0; t_rvalid = 1'b0;
      @(negedge clk);
      check("to good rd_valid", {31'h0, t_rd_valid}, 32'h1);
      check("to good rd_dat", t_rd_dat, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      t_mem_rd = 1'b0;
      @(posedge clk); #1;

      // WAIT timeout: grant, then never return data.
      t_mem_rd = 1'b1;
      @(posedge clk); #1;
      t_gnt = 1'b1;
      @(posedge clk); #1;
      t_gnt = 1'b0;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         check($sformatf("to wait%0d fault", w), {31'h0, t_fault}, 32'h0);
         check($sformatf("to wait%0d stall", w), {31'h0, t_stall}, 32'h1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("to wait fault", {31'h0, t_fault}, 32'h1);
      check("to wait stall", {31'h0, t_stall}, 32'h0);
      check("to wait rd_dat", t_rd_dat, 32'h0);
      check("to wait rd_valid", {31'h0, t_rd_valid}, 32'h0);
      @(posedge clk); #1;
      t_mem_rd = 1'b0;
      @(negedge clk);
      check("to wait fault cleared", {31'h0, t_fault}, 32'h0);
      @(posedge clk); #1;

      // REQ timeout: grant never comes.
      t_mem_rd = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         check($sformatf("to req%0d bus_req", r), {31'h0, t_bus_req}, 32'h1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("to req fault", {31'h0, t_fault}, 32'h1);
      check("to req bus_req dropped", {31'h0, t_bus_req}, 32'h0);
      check("to req stall", {31'h0, t_stall}, 32'h0);
      @(posedge clk); #1;
      t_mem_rd = 1'b0;
      @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
